// File: rtl/seq_detect_scheduler_if.sv
// seq_detect_scheduler_if: bundles the requester-side bus and the shared
// detector hookup of seq_detect_scheduler. The master modport is the
// scheduler; the slave modport is the requesters plus the detector.
interface seq_detect_scheduler_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  parameter int CNT_W   = 4
);
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        grant;
  logic                      det_w;
  logic                      det_rst_n;
  logic                      det_z;
  logic                      done;
  logic [ID_W-1:0]           done_id;
  logic [CNT_W-1:0]          hit_count;
  logic                      busy;

  modport master (
    input  req, req_data, det_z,
    output grant, det_w, det_rst_n, done, done_id, hit_count, busy
  );

  modport slave (
    output req, req_data, det_z,
    input  grant, det_w, det_rst_n, done, done_id, hit_count, busy
  );
endinterface

// File: rtl/seq_detect_scheduler.sv
// seq_detect_scheduler: time-shares one serial four-in-a-row detector among
// NUM_REQ byte-wide requesters. Each grant flushes the detector, shifts the
// captured byte in MSB first, counts z=1 samples and reports count and id.
// Grant is high for FLUSH + DATA_W SHIFT + DRAIN + DONE cycles, so the done
// pulse lands in the (DATA_W+3)-th grant cycle.
// Build option: define SEQ_SCHED_FIXED_PRIO_EN for fixed priority (index 0
// wins); default is round-robin.
module seq_detect_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  parameter int CNT_W   = 4
) (
  input  logic                   Clk,
  input  logic                   Reset,
  seq_detect_scheduler_if.master bus
);

  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int K_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [K_W-1:0]   K_LAST  = K_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [ID_W:0]    N_WIDE  = (ID_W+1)'(NUM_REQ);
  localparam logic [ID_W-1:0]  ID_LAST = ID_W'(NUM_REQ - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FLUSH = 3'd1,
    ST_SHIFT = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Hit counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    sat_inc = (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  state_t              state_q, state_d;
  logic [ID_W-1:0]     ptr_q, ptr_d;
  logic [ID_W-1:0]     winner_q, winner_d;
  logic [DATA_W-1:0]   sr_q, sr_d;
  logic [K_W-1:0]      k_q, k_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic                det_w_q, det_w_d;
  logic                det_rst_n_q, det_rst_n_d;
  logic                done_q, done_d;
  logic [ID_W-1:0]     done_id_q, done_id_d;
  logic [CNT_W-1:0]    hit_count_q, hit_count_d;
  logic                busy_q, busy_d;

  logic                arb_found_s;
  logic [ID_W-1:0]     arb_win_s;
  logic [ID_W-1:0]     arb_start_s;
  logic [ID_W:0]       arb_idx_s;
  logic [ID_W-1:0]     ptr_next_s;
  logic [DATA_W-1:0]   data_s [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign data_s[g] = bus.req_data[g*DATA_W +: DATA_W];
  end

`ifdef SEQ_SCHED_FIXED_PRIO_EN
  assign arb_start_s = '0;
  assign ptr_next_s  = '0;
`else
  assign arb_start_s = ptr_q;
  assign ptr_next_s  = (arb_win_s == ID_LAST) ? '0 : arb_win_s + ID_W'(1);
`endif

  // Scan requests circularly from the start index; the first pending one wins.
  always_comb begin
    arb_found_s = 1'b0;
    arb_win_s   = '0;
    arb_idx_s   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      arb_idx_s = {1'b0, arb_start_s} + (ID_W+1)'(i);
      arb_idx_s = (arb_idx_s >= N_WIDE) ? arb_idx_s - N_WIDE : arb_idx_s;
      if (!arb_found_s && bus.req[arb_idx_s[ID_W-1:0]]) begin
        arb_found_s = 1'b1;
        arb_win_s   = arb_idx_s[ID_W-1:0];
      end else begin
        arb_found_s = arb_found_s;
      end
    end
  end

  // Next state plus next values of every registered output.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    winner_d    = winner_q;
    sr_d        = sr_q;
    k_d         = k_q;
    cnt_d       = cnt_q;
    grant_d     = grant_q;
    det_w_d     = 1'b0;
    det_rst_n_d = 1'b1;
    done_d      = 1'b0;
    done_id_d   = done_id_q;
    hit_count_d = hit_count_q;
    case (state_q)
      ST_IDLE: begin
        if (arb_found_s) begin
          state_d     = ST_FLUSH;
          winner_d    = arb_win_s;
          ptr_d       = ptr_next_s;
          sr_d        = data_s[arb_win_s];
          cnt_d       = '0;
          grant_d     = NUM_REQ'(1) << arb_win_s;
          det_rst_n_d = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FLUSH: begin
        state_d = ST_SHIFT;
        k_d     = '0;
        det_w_d = sr_q[DATA_W-1];
        sr_d    = sr_q << 1;
      end
      ST_SHIFT: begin
        // z in the first shift cycle still shows the flushed detector.
        if ((k_q != '0) && bus.det_z) begin
          cnt_d = sat_inc(cnt_q);
        end else begin
          cnt_d = cnt_q;
        end
        if (k_q == K_LAST) begin
          state_d = ST_DRAIN;
        end else begin
          k_d     = k_q + K_W'(1);
          det_w_d = sr_q[DATA_W-1];
          sr_d    = sr_q << 1;
        end
      end
      ST_DRAIN: begin
        // One more z sample: it reflects the last bit shifted in.
        if (bus.det_z) begin
          cnt_d = sat_inc(cnt_q);
        end else begin
          cnt_d = cnt_q;
        end
        state_d     = ST_DONE;
        done_d      = 1'b1;
        done_id_d   = winner_q;
        hit_count_d = cnt_d;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State, datapath and output registers; reset aborts any transaction.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      winner_q    <= '0;
      sr_q        <= '0;
      k_q         <= '0;
      cnt_q       <= '0;
      grant_q     <= '0;
      det_w_q     <= 1'b0;
      det_rst_n_q <= 1'b0;
      done_q      <= 1'b0;
      done_id_q   <= '0;
      hit_count_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      winner_q    <= winner_d;
      sr_q        <= sr_d;
      k_q         <= k_d;
      cnt_q       <= cnt_d;
      grant_q     <= grant_d;
      det_w_q     <= det_w_d;
      det_rst_n_q <= det_rst_n_d;
      done_q      <= done_d;
      done_id_q   <= done_id_d;
      hit_count_q <= hit_count_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.grant     = grant_q;
  assign bus.det_w     = det_w_q;
  assign bus.det_rst_n = det_rst_n_q;
  assign bus.done      = done_q;
  assign bus.done_id   = done_id_q;
  assign bus.hit_count = hit_count_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_seq_detect_scheduler.sv
// tb_seq_detect_scheduler: table-driven, hand-written and randomized checks of
// seq_detect_scheduler against a shared four-in-a-row detector model (z=1 when
// the last four w bits are equal) and an arbitration/hit-count reference.
module tb_seq_detect_scheduler;
  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 8;
  localparam int CNT_W   = 4;

  logic Clk;
  logic Reset;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   m_ptr    = 0;

  seq_detect_scheduler_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

  seq_detect_scheduler #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Shared detector: Moore z, asynchronous reset via det_rst_n.
  logic [3:0] dh_q;
  logic [2:0] dn_q;
  always_ff @(posedge Clk or negedge bus.det_rst_n) begin
    if (!bus.det_rst_n) begin
      dh_q <= 4'h0;
      dn_q <= 3'd0;
    end else begin
      dh_q <= {dh_q[2:0], bus.det_w};
      if (dn_q < 3'd4) dn_q <= dn_q + 3'd1;
    end
  end
  assign bus.det_z = (dn_q == 3'd4) && ((dh_q == 4'hF) || (dh_q == 4'h0));

  typedef struct {
    string      nm;
    logic [3:0] req;
    logic [7:0] data;
    int         id;
    int         hits;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  // Reference: number of 4-bit windows (in send order) whose bits are all equal.
  function automatic int model_hits(input logic [7:0] b);
    int h;
    logic s [DATA_W];
    h = 0;
    for (int j = 0; j < DATA_W; j++) s[j] = b[DATA_W-1-j];
    for (int j = 3; j < DATA_W; j++)
      if (s[j] == s[j-1] && s[j] == s[j-2] && s[j] == s[j-3]) h++;
    if (h > (1 << CNT_W) - 1) h = (1 << CNT_W) - 1;
    return h;
  endfunction

  // Reference arbitration: first pending requester at or after the pointer.
  function automatic int model_pick(input logic [3:0] r, input int p);
    int k;
`ifdef SEQ_SCHED_FIXED_PRIO_EN
    p = 0;
`endif
    for (int i = 0; i < NUM_REQ; i++) begin
      k = (p + i) % NUM_REQ;
      if (((r >> k) & 4'b0001) != 4'b0000) return k;
    end
    return 0;
  endfunction

  task automatic set_all(input logic [7:0] b);
    for (int i = 0; i < NUM_REQ; i++) bus.req_data[i*DATA_W +: DATA_W] = b;
  endtask

  task automatic wait_grant(input string nm, output bit ok);
    int n;
    n = 0;
    while (bus.grant == 4'b0000 && n < 40) begin
      @(negedge Clk);
      n++;
    end
    ok = (bus.grant != 4'b0000);
    if (!ok) begin
      n_checks++;
      $display("FAIL %s: no grant within %0d cycles", nm, n);
    end
  endtask

  task automatic do_reset();
    Reset = 1'b0;
    bus.req = 4'b0000;
    repeat (2) @(negedge Clk);
    chk("reset outputs", {bus.grant, bus.det_w, bus.det_rst_n, bus.done,
                          bus.done_id, bus.hit_count, bus.busy}, 32'd0);
    Reset = 1'b1;
    @(negedge Clk);
    chk("idle det_rst_n/busy", {bus.det_rst_n, bus.busy, bus.grant}, 32'h20);
  endtask

  // One complete transaction: grant, flush, serial bits, drain, done, idle gap.
  task automatic run_txn(input string nm, input int exp_id, input logic [7:0] exp_byte,
                         input int exp_hit, input bit scramble);
    bit         ok;
    bit         rst_bad;
    bit         early_done;
    logic [7:0] wseq;
    logic [3:0] oh;
    oh = 4'b0001 << exp_id;
    wait_grant(nm, ok);
    if (ok) begin
      chk({nm, " grant"}, 32'(bus.grant), 32'(oh));
      chk({nm, " flush"}, {bus.busy, bus.det_rst_n, bus.det_w}, 32'h4);
      wseq = 8'h00;
      rst_bad = 1'b0;
      early_done = bus.done;
      for (int c = 1; c <= DATA_W; c++) begin
        @(negedge Clk);
        wseq = {wseq[6:0], bus.det_w};
        if (!bus.det_rst_n) rst_bad = 1'b1;
        if (bus.done) early_done = 1'b1;
        if (scramble && c == 2) begin
          bus.req_data = $urandom();
          bus.req = 4'($urandom_range(0, 15));
        end
      end
      chk({nm, " det_w seq"}, 32'(wseq), 32'(exp_byte));
      @(negedge Clk);
      if (bus.done) early_done = 1'b1;
      chk({nm, " drain"}, {rst_bad, bus.det_w, bus.det_rst_n}, 32'h1);
      chk({nm, " no early done"}, 32'(early_done), 32'd0);
      @(negedge Clk);
      chk({nm, " done"}, 32'(bus.done), 32'd1);
      chk({nm, " done_id"}, 32'(bus.done_id), 32'(exp_id));
      chk({nm, " hit_count"}, 32'(bus.hit_count), 32'(exp_hit));
      chk({nm, " grant held"}, 32'(bus.grant), 32'(oh));
      @(negedge Clk);
      chk({nm, " idle gap"}, {bus.done, bus.grant, bus.busy}, 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit   ok;
    int   exp_id;
    int   seq_ids [3];
    logic [3:0] r;
    logic [7:0] b;

    tbl[0] = '{"t_6F", 4'b0001, 8'b01101111, 0, 1};
    tbl[1] = '{"t_F0", 4'b0010, 8'b11110000, 1, 2};
    tbl[2] = '{"t_FF", 4'b0010, 8'hFF,       1, 5};
    tbl[3] = '{"t_55", 4'b0010, 8'h55,       1, 0};
    tbl[4] = '{"t_00", 4'b0100, 8'h00,       2, 5};
    tbl[5] = '{"t_87", 4'b1000, 8'b10000111, 3, 1};
    tbl[6] = '{"t_3C", 4'b1000, 8'b00111100, 3, 1};
    tbl[7] = '{"t_F8", 4'b0001, 8'hF8,       0, 2};

    Reset = 1'b0;
    bus.req = 4'b0000;
    bus.req_data = '0;
    repeat (2) @(negedge Clk);
    chk("rst grant", 32'(bus.grant), 32'd0);
    chk("rst det_rst_n", 32'(bus.det_rst_n), 32'd0);
    chk("rst done/id/count", {bus.done, bus.done_id, bus.hit_count, bus.det_w, bus.busy}, 32'd0);
    Reset = 1'b1;
    @(negedge Clk);
    chk("first idle", {bus.det_rst_n, bus.busy, bus.grant, bus.done}, 32'h40);

    // Single-requester vectors.
    for (int v = 0; v < 8; v++) begin
      bus.req_data = $urandom();
      bus.req_data[tbl[v].id*DATA_W +: DATA_W] = tbl[v].data;
      bus.req = tbl[v].req;
      run_txn(tbl[v].nm, tbl[v].id, tbl[v].data, tbl[v].hits, 1'b0);
    end
    bus.req = 4'b0000;

    // All requesters held: round-robin order 0,1,2,3,0 (fixed priority: 0 always).
    do_reset();
    set_all(8'h0F);
    bus.req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
`ifdef SEQ_SCHED_FIXED_PRIO_EN
      exp_id = 0;
`else
      exp_id = i % NUM_REQ;
`endif
      run_txn($sformatf("rr_%0d", i), exp_id, 8'h0F, 2, 1'b0);
    end
    bus.req = 4'b0000;

    // Requesters 1 and 3 held.
    do_reset();
    set_all(8'h0F);
`ifdef SEQ_SCHED_FIXED_PRIO_EN
    seq_ids = '{1, 1, 1};
`else
    seq_ids = '{1, 3, 1};
`endif
    bus.req = 4'b1010;
    for (int i = 0; i < 3; i++) run_txn($sformatf("pair_%0d", i), seq_ids[i], 8'h0F, 2, 1'b0);
    bus.req = 4'b0000;

    // Reset in SHIFT cycle 4 aborts; pending request restarts from pointer 0.
    do_reset();
    set_all(8'h0F);
    bus.req = 4'b0010;
    run_txn("rst_pre", 1, 8'h0F, 2, 1'b0);
    bus.req_data[0*DATA_W +: DATA_W] = 8'hF0;
    bus.req_data[2*DATA_W +: DATA_W] = 8'hFF;
    bus.req_data[3*DATA_W +: DATA_W] = 8'h00;
    bus.req = 4'b1101;
    wait_grant("rst_mid", ok);
    if (ok) begin
`ifdef SEQ_SCHED_FIXED_PRIO_EN
      chk("rst_mid grant", 32'(bus.grant), 32'h1);
`else
      chk("rst_mid grant", 32'(bus.grant), 32'h4);
`endif
      repeat (5) @(negedge Clk);
      chk("rst_mid busy", 32'(bus.busy), 32'd1);
      Reset = 1'b0;
      #1;
      chk("rst_mid abort", {bus.grant, bus.det_rst_n, bus.done, bus.busy}, 32'd0);
      @(negedge Clk);
      chk("rst_mid held", {bus.done, bus.det_rst_n, bus.grant}, 32'd0);
      Reset = 1'b1;
      run_txn("rst_post", 0, 8'hF0, 2, 1'b0);
    end
    bus.req = 4'b0000;

    // Randomized requests and data, with data/req churn after capture.
    do_reset();
    m_ptr = 0;
    for (int n = 0; n < 30; n++) begin
      r = 4'($urandom_range(1, 15));
      bus.req_data = $urandom();
      bus.req = r;
      exp_id = model_pick(r, m_ptr);
      b = bus.req_data[exp_id*DATA_W +: DATA_W];
      run_txn($sformatf("rand_%0d", n), exp_id, b, model_hits(b), 1'b1);
`ifdef SEQ_SCHED_FIXED_PRIO_EN
      m_ptr = 0;
`else
      m_ptr = (exp_id + 1) % NUM_REQ;
`endif
    end
    bus.req = 4'b0000;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
